// File: rtl/dekatron_counter_arbiter.sv
// Round-robin arbiter sharing one DekatronCounter between two requesters, issuing INC/DEC bursts or single SET/ZERO steps.
// Optional: DEKATRON_ARB_STOP_ON_ZERO_EN ends a DEC burst early once the counter reports zero.
module dekatron_counter_arbiter #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [1:0]           ReqValid,
    input  logic [3:0]           ReqOp,
    input  logic [2*WIDTH-1:0]   ReqIn,
    input  logic [2*CNT_W-1:0]   ReqCount,
    output logic [1:0]           ReqAck,
    output logic                 Owner,
    output logic                 Busy,
    output logic                 CntRequest,
    output logic                 CntDec,
    output logic                 CntSet,
    output logic                 CntSetZero,
    output logic [WIDTH-1:0]     CntIn,
    input  logic                 CntReady,
    input  logic                 CntZero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_SET  = 2'b10,
        OP_ZERO = 2'b11
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   in_q, in_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               owner_q, owner_d;
    // Port favoured when both request; equals the port that was not served last.
    logic               pri_q, pri_d;
    logic               stop_zero;
    logic               grant;
    logic [CNT_W-1:0]   grant_cnt;
    logic               is_step_op;

`ifdef DEKATRON_ARB_STOP_ON_ZERO_EN
    assign stop_zero = (op_q == OP_DEC) && CntZero;
`else
    logic unused_cnt_zero;
    assign unused_cnt_zero = CntZero;
    assign stop_zero       = 1'b0;
`endif

    assign is_step_op = (op_q == OP_INC) || (op_q == OP_DEC);
    assign grant      = (ReqValid == 2'b11) ? pri_q : ReqValid[1];
    assign grant_cnt  = grant ? ReqCount[2*CNT_W-1:CNT_W] : ReqCount[CNT_W-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_INC;
            in_q    <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            in_q    <= in_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            pri_q   <= pri_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        in_d       = in_q;
        rem_d      = rem_q;
        owner_d    = owner_q;
        pri_d      = pri_q;
        CntRequest = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|ReqValid) && CntReady) begin
                    owner_d = grant;
                    op_d    = op_e'(grant ? ReqOp[3:2] : ReqOp[1:0]);
                    in_d    = grant ? ReqIn[2*WIDTH-1:WIDTH] : ReqIn[WIDTH-1:0];
                    rem_d   = (grant_cnt == '0) ? CNT_W'(1) : grant_cnt;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (stop_zero) begin
                    state_d = S_DONE;
                end else begin
                    CntRequest = 1'b1;
                    if (is_step_op) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (CntReady) begin
                    state_d = (is_step_op && (rem_q != '0)) ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                pri_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Op decode is masked in IDLE so the counter sees a clean, idle bus between grants.
    always_comb begin
        Busy       = (state_q != S_IDLE);
        Owner      = owner_q;
        CntDec     = Busy && (op_q == OP_DEC);
        CntSet     = Busy && (op_q == OP_SET);
        CntSetZero = Busy && (op_q == OP_ZERO);
        CntIn      = Busy ? in_q : '0;
        ReqAck     = '0;
        if (state_q == S_DONE) begin
            ReqAck[owner_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dekatron_counter_arbiter.sv
// Scoreboard bench for dekatron_counter_arbiter with a behavioural BCD DekatronCounter model.
// DEC-at-zero expectations follow DEKATRON_ARB_STOP_ON_ZERO_EN.
module tb_dekatron_counter_arbiter;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_ZERO = 2'b11;

    logic                 Clk;
    logic                 Rst_n;
    logic [1:0]           ReqValid;
    logic [3:0]           ReqOp;
    logic [2*WIDTH-1:0]   ReqIn;
    logic [2*CNT_W-1:0]   ReqCount;
    logic [1:0]           ReqAck;
    logic                 Owner;
    logic                 Busy;
    logic                 CntRequest;
    logic                 CntDec;
    logic                 CntSet;
    logic                 CntSetZero;
    logic [WIDTH-1:0]     CntIn;
    logic                 CntReady;
    logic                 CntZero;

    logic [WIDTH-1:0]     cnt_val;
    int                   rdy_cnt;
    logic                 force_low;
    logic                 preset;
    logic [WIDTH-1:0]     preset_val;

    typedef struct {
        int               port;
        logic [1:0]       op;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_val;
        int               exp_pulses;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    dekatron_counter_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqOp(ReqOp), .ReqIn(ReqIn),
        .ReqCount(ReqCount), .ReqAck(ReqAck), .Owner(Owner), .Busy(Busy),
        .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet), .CntSetZero(CntSetZero),
        .CntIn(CntIn), .CntReady(CntReady), .CntZero(CntZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [WIDTH-1:0] bcd_step(input logic [WIDTH-1:0] v, input logic dec);
        logic [WIDTH-1:0] r;
        logic [3:0] dg;
        r = v;
        for (int d = 0; d < 3; d++) begin
            dg = r[4*d +: 4];
            if (!dec) begin
                if (dg == 4'd9) r[4*d +: 4] = 4'd0;
                else begin r[4*d +: 4] = dg + 4'd1; return r; end
            end else begin
                if (dg == 4'd0) r[4*d +: 4] = 4'd9;
                else begin r[4*d +: 4] = dg - 4'd1; return r; end
            end
        end
        return r;
    endfunction

    // Counter model: acts on each Request edge, then holds Ready low for 5 cycles.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_val <= '0;
            rdy_cnt <= 0;
        end else if (preset) begin
            cnt_val <= preset_val;
        end else if (CntRequest) begin
            if (CntSetZero)  cnt_val <= '0;
            else if (CntSet) cnt_val <= CntIn;
            else             cnt_val <= bcd_step(cnt_val, CntDec);
            rdy_cnt <= 5;
        end else if (rdy_cnt != 0) begin
            rdy_cnt <= rdy_cnt - 1;
        end
    end

    assign CntReady = (rdy_cnt == 0) && !force_low;
    assign CntZero  = (cnt_val == '0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        Rst_n     = 1'b0;
        ReqValid  = '0;
        preset    = 1'b0;
        force_low = 1'b0;
        sb.delete();
        pulses    = 0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_preset(input logic [WIDTH-1:0] v);
        preset_val = v;
        preset     = 1'b1;
        @(negedge Clk);
        preset     = 1'b0;
    endtask

    task automatic issue(input int port, input logic [1:0] op, input logic [WIDTH-1:0] din,
                         input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] exp_val,
                         input int exp_pulses);
        sb_entry_t e;
        ReqOp[2*port +: 2]         = op;
        ReqIn[WIDTH*port +: WIDTH] = din;
        ReqCount[CNT_W*port +: CNT_W] = cnt;
        ReqValid[port]             = 1'b1;
        e.port = port; e.op = op; e.din = din; e.exp_val = exp_val; e.exp_pulses = exp_pulses;
        sb.push_back(e);
    endtask

    task automatic run_until_acks(input int n, input int budget);
        int got;
        int cyc;
        logic prev_req;
        sb_entry_t e;
        got = 0; cyc = 0; prev_req = 1'b0;
        while (got < n && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (CntRequest) begin
                pulses++;
                check_eq("req_gap", {31'd0, prev_req}, 32'd0);
                if (sb.size() != 0) begin
                    check_eq("cnt_dec", {31'd0, CntDec}, {31'd0, sb[0].op == OP_DEC});
                    check_eq("cnt_set", {31'd0, CntSet}, {31'd0, sb[0].op == OP_SET});
                    check_eq("cnt_zero_op", {31'd0, CntSetZero}, {31'd0, sb[0].op == OP_ZERO});
                    if (sb[0].op == OP_SET) check_eq("cnt_in", {20'd0, CntIn}, {20'd0, sb[0].din});
                end
            end
            prev_req = CntRequest;
            if (ReqAck != 2'b00) begin
                got++;
                if (sb.size() == 0) begin
                    check_eq("ack_unexpected", {30'd0, ReqAck}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ack_port", {30'd0, ReqAck}, 32'd1 << e.port);
                    check_eq("owner", {31'd0, Owner}, e.port);
                    check_eq("pulses", pulses, e.exp_pulses);
                    check_eq("cnt_val", {20'd0, cnt_val}, {20'd0, e.exp_val});
                end
                pulses = 0;
                ReqValid = ReqValid & ~ReqAck;
            end
        end
        if (got < n) check_eq("ack_timeout", got, n);
    endtask

    initial begin
        int dly;
        logic bad;
        ReqOp = '0; ReqIn = '0; ReqCount = '0; preset_val = '0;
        apply_reset();

        check_eq("rst_busy",  {31'd0, Busy}, 32'd0);
        check_eq("rst_ack",   {30'd0, ReqAck}, 32'd0);
        check_eq("rst_req",   {31'd0, CntRequest}, 32'd0);
        check_eq("rst_owner", {31'd0, Owner}, 32'd0);
        check_eq("rst_flags", {29'd0, CntDec, CntSet, CntSetZero}, 32'd0);
        check_eq("rst_in",    {20'd0, CntIn}, 32'd0);

        // INC burst of 3 from 000, then count 0 behaves as 1
        issue(0, OP_INC, 12'h000, 4'd3, 12'h003, 3);
        run_until_acks(1, 200);
        issue(0, OP_INC, 12'h000, 4'd0, 12'h004, 1);
        run_until_acks(1, 100);

        // Both valid after reset: port 0 first, then port 1
        apply_reset();
        do_preset(12'h010);
        issue(0, OP_INC, 12'h000, 4'd1, 12'h011, 1);
        issue(1, OP_DEC, 12'h000, 4'd1, 12'h010, 1);
        run_until_acks(2, 200);

        // Port 0 re-requests with port 1 pending: port 1 was last, so port 0 goes first, then port 1
        issue(0, OP_INC, 12'h000, 4'd1, 12'h011, 1);
        issue(1, OP_INC, 12'h000, 4'd1, 12'h012, 1);
        run_until_acks(2, 200);

        // SET is always a single step regardless of count; ZERO clears
        issue(1, OP_SET, 12'h123, 4'd0, 12'h123, 1);
        run_until_acks(1, 100);
        issue(1, OP_SET, 12'h456, 4'd7, 12'h456, 1);
        run_until_acks(1, 100);
        issue(0, OP_ZERO, 12'h000, 4'd5, 12'h000, 1);
        run_until_acks(1, 100);

        // DEC burst of 2 from 001
        do_preset(12'h001);
`ifdef DEKATRON_ARB_STOP_ON_ZERO_EN
        issue(0, OP_DEC, 12'h000, 4'd2, 12'h000, 1);
`else
        issue(0, OP_DEC, 12'h000, 4'd2, 12'h999, 2);
`endif
        run_until_acks(1, 200);

        // Reset during WAIT of a 5-step INC
        apply_reset();
        issue(0, OP_INC, 12'h000, 4'd5, 12'h005, 5);
        dly = 0;
        while (!CntRequest && dly < 20) begin @(negedge Clk); dly++; end
        check_eq("first_pulse_seen", {31'd0, CntRequest}, 32'd1);
        repeat (2) @(negedge Clk);
        check_eq("in_wait_busy", {31'd0, Busy}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check_eq("midrst_outs", {26'd0, Busy, CntRequest, ReqAck, CntDec, CntSet},  32'd0);
        check_eq("midrst_in",   {20'd0, CntIn}, 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (ReqAck != 2'b00 || CntRequest) bad = 1'b1;
        end
        check_eq("midrst_no_ack", {31'd0, bad}, 32'd0);
        ReqValid = '0;
        sb.delete();
        pulses = 0;
        Rst_n = 1'b1;
        @(negedge Clk);
        issue(0, OP_INC, 12'h000, 4'd1, 12'h001, 1);
        run_until_acks(1, 100);

        // Ready low in IDLE blocks grant
        apply_reset();
        force_low = 1'b1;
        issue(0, OP_INC, 12'h000, 4'd1, 12'h001, 1);
        bad = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (CntRequest || Busy) bad = 1'b1;
        end
        check_eq("blocked_idle", {31'd0, bad}, 32'd0);
        force_low = 1'b0;
        dly = 0;
        while (!CntRequest && dly < 10) begin @(negedge Clk); dly++; end
        check_eq("unblock_delay_ok", {31'd0, (dly >= 1) && (dly <= 2)}, 32'd1);
        pulses = CntRequest ? 1 : 0;
        run_until_acks(1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
